// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues host I2C commands and runs them one at a time through an external byte driver
module i2c_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 4096
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_rw,
   input  logic [6:0]                  cmd_addr,
   input  logic [7:0]                  cmd_wdata,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        drv_start,
   output logic                        drv_rw,
   output logic [6:0]                  drv_addr,
   output logic [7:0]                  drv_wdata,
   input  logic                        drv_busy,
   input  logic [7:0]                  drv_rdata,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [7:0]                  rsp_rdata,
   output logic                        rsp_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT_BUSY = 3'd2, WAIT_DONE = 3'd3, RESP = 3'd4;

   logic [2:0]    state;
   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;
   logic          push, pop, expired, waiting;

   // pops are gated by the registered count, so an entry is visible one cycle after its push
   assign cmd_ready = fifo_count != FULL;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = state == IDLE && fifo_count != '0;
   assign drv_start = state == ISSUE;
   assign rsp_valid = state == RESP;
   assign waiting   = state == WAIT_BUSY || state == WAIT_DONE;
   assign expired   = cnt == LAST;

   // command storage: {rw, addr, wdata}, no reset needed since pointers define validity
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk)
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      end

   // transaction sequencer: issue, wait for busy to rise then fall, report, wait for host
   always_ff @(posedge clk)
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         drv_rw    <= 1'b0;
         drv_addr  <= '0;
         drv_wdata <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         cnt <= waiting ? cnt + 1'b1 : '0;
         case (state)
            IDLE:
               if (pop) begin
                  {drv_rw, drv_addr, drv_wdata} <= mem[rd_ptr];
                  state <= ISSUE;
               end
            ISSUE: state <= WAIT_BUSY;
            WAIT_BUSY:
               if (drv_busy) begin
                  cnt   <= '0;
                  state <= WAIT_DONE;
               end else if (expired) begin
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end
            WAIT_DONE:
               if (!drv_busy) begin
                  rsp_err   <= 1'b0;
                  rsp_rdata <= drv_rw ? drv_rdata : '0;
                  state     <= RESP;
               end else if (expired) begin
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end
            RESP: if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: directed table, corner sequences and randomized traffic against a transaction model
module tb_i2c_cmd_sequencer;
   localparam int TO = 16;
   localparam int NR = 40;

   logic       clk, rst, cmd_valid, cmd_ready, cmd_rw, drv_start, drv_rw, drv_busy;
   logic       rsp_valid, rsp_ready, rsp_err;
   logic [6:0] cmd_addr, drv_addr;
   logic [7:0] cmd_wdata, drv_wdata, drv_rdata, rsp_rdata;
   logic [2:0] fifo_count;

   i2c_cmd_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .fifo_count(fifo_count), .drv_start(drv_start),
      .drv_rw(drv_rw), .drv_addr(drv_addr), .drv_wdata(drv_wdata), .drv_busy(drv_busy),
      .drv_rdata(drv_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err)
   );

   typedef struct {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
      int         d0;
      int         d1;
      logic [7:0] rd;
      logic       err;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t        vecs [6];
   int          total, passed, n, bad, got, c_cyc, r_sel, r_d0, r_d1;
   logic        ok, done, hold, r_err;
   logic [7:0]  r_rd;
   logic [8:0]  held, e;
   logic [15:0] r_c;
   logic [15:0] cmd_q [$];
   logic [8:0]  rsp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // offer one command until accepted; the model queue records it before the accepting edge
   task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] d);
      int k = 0;
      cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
      @(negedge clk);
      while (!cmd_ready && k < 400) begin @(negedge clk); k++; end
      check("push_accept", cmd_ready, 1);
      if (cmd_ready) cmd_q.push_back({rw, a, d});
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(output logic seen);
      int k = 0;
      while (!drv_start && k < 300) begin @(posedge clk); #1; k++; end
      seen = drv_start;
   endtask

   task automatic wait_rsp(output logic seen);
      int k = 0;
      @(negedge clk);
      while (!rsp_valid && k < 300) begin @(negedge clk); k++; end
      seen = rsp_valid;
   endtask

   // driver model, called in the drv_start cycle: busy rises after d0 idle cycles, then stays high d1 cycles;
   // d0 >= TO means busy never rises
   task automatic drive_busy(input int d0, input int d1, input logic [7:0] rd);
      @(posedge clk); #1;
      check("start_pulse", drv_start, 0);
      if (d0 < TO) begin
         repeat (d0) begin @(posedge clk); #1; end
         drv_busy = 1'b1;
         repeat (d1 + 1) begin @(posedge clk); #1; end
         drv_busy = 1'b0;
         drv_rdata = rd;
      end
   endtask

   initial begin
      total = 0; passed = 0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      drv_busy = 1'b0; drv_rdata = '0; rsp_ready = 1'b1;
      vecs[0] = '{1'b0, 7'h50, 8'hA5, 0, 9, 8'hFF, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 7'h1D, 8'h00, 2, 3, 8'h3C, 1'b0, 8'h3C};
      vecs[2] = '{1'b1, 7'h7F, 8'h00, 15, 0, 8'h81, 1'b0, 8'h81};
      vecs[3] = '{1'b1, 7'h01, 8'h00, 0, 15, 8'hC3, 1'b0, 8'hC3};
      vecs[4] = '{1'b1, 7'h02, 8'h00, 0, 16, 8'h5A, 1'b1, 8'h00};
      vecs[5] = '{1'b0, 7'h2A, 8'h00, 16, 0, 8'h99, 1'b1, 8'h00};
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", cmd_ready, 1);
      check("rst_count", fifo_count, 0);
      check("rst_start", drv_start, 0);
      check("rst_drv", {drv_rw, drv_addr, drv_wdata}, 0);
      check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         push(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
         wait_start(ok);
         check("tbl_start", ok, 1);
         check("tbl_drv", {drv_rw, drv_addr, drv_wdata}, {vecs[i].rw, vecs[i].addr, vecs[i].wdata});
         drive_busy(vecs[i].d0, vecs[i].d1, vecs[i].rd);
         wait_rsp(ok);
         check("tbl_rsp_seen", ok, 1);
         check("tbl_rsp", {rsp_err, rsp_rdata}, {vecs[i].err, vecs[i].exp_rd});
         check("tbl_drv_hold", {drv_rw, drv_addr, drv_wdata}, {vecs[i].rw, vecs[i].addr, vecs[i].wdata});
         @(posedge clk); #1;
      end

      // busy stuck high: error exactly TO cycles after WAIT_DONE entry
      push(1'b1, 7'h0F, 8'h00);
      wait_start(ok);
      @(posedge clk); #1;
      drv_busy = 1'b1;
      @(posedge clk); #1;
      n = 0;
      while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("stuck_cycles", n, TO);
      check("stuck_rsp", {rsp_err, rsp_rdata}, 9'h100);
      drv_busy = 1'b0;
      @(posedge clk); #1;

      // host stalls the response for 20 cycles with a second command queued
      rsp_ready = 1'b0;
      push(1'b0, 7'h33, 8'h11);
      push(1'b1, 7'h44, 8'h22);
      wait_rsp(ok);
      check("stall_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h300);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!rsp_valid || {rsp_err, rsp_rdata} != 9'h100 || drv_start || fifo_count != 3'd1) bad++;
      end
      check("stall_hold", bad, 0);
      check("stall_drv", drv_addr, 7'h33);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      wait_start(ok);
      check("stall_next", {ok, drv_rw, drv_addr, drv_wdata}, {1'b1, 1'b1, 7'h44, 8'h22});
      wait_rsp(ok);
      check("stall_next_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h300);
      @(posedge clk); #1;

      // five pushes, driver never busy: FIFO fills, drains one per timeout, responses in order
      for (int i = 0; i < 5; i++) push(1'b0, 7'(16 + i), 8'(i));
      check("full_count", fifo_count, 4);
      check("full_ready", cmd_ready, 0);
      check("full_head", drv_addr, 7'h10);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            wait_start(ok);
            check("full_order", {ok, drv_addr, drv_wdata}, {1'b1, 7'(16 + i), 8'(i)});
            check("full_drop", fifo_count, 4 - i);
         end
         wait_rsp(ok);
         check("full_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h300);
         @(posedge clk); #1;
      end

      // reset while waiting for busy to fall with two commands queued
      push(1'b1, 7'h61, 8'h00);
      push(1'b0, 7'h62, 8'h01);
      push(1'b0, 7'h63, 8'h02);
      drv_busy = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_count", fifo_count, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_empty", {cmd_ready, fifo_count}, 4'h8);
      check("rst_mid_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
      check("rst_mid_drv", {drv_start, drv_rw, drv_addr, drv_wdata}, 0);
      rst = 1'b0;
      drv_busy = 1'b0;
      bad = 0;
      repeat (20) begin @(negedge clk); if (drv_start || rsp_valid) bad++; end
      check("rst_mid_quiet", bad, 0);
      @(posedge clk); #1;
      push(1'b1, 7'h70, 8'h77);
      @(posedge clk); #1;
      check("rst_mid_restart", {drv_start, drv_rw, drv_addr, drv_wdata}, {1'b1, 1'b1, 7'h70, 8'h77});
      drive_busy(0, 0, 8'hE7);
      wait_rsp(ok);
      check("rst_mid_rsp2", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'hE7});
      @(posedge clk); #1;

      // randomized traffic: producer, driver model and response consumer in parallel
      cmd_q.delete();
      rsp_q.delete();
      done = 1'b0; got = 0; c_cyc = 0; hold = 1'b0; held = '0;
      fork
         begin
            for (int i = 0; i < NR; i++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               push(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
            end
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               if (drv_start) begin
                  r_sel = $urandom_range(0, 9);
                  r_d0 = (r_sel == 0) ? TO : $urandom_range(0, 4);
                  r_d1 = (r_sel == 1) ? TO : $urandom_range(0, 6);
                  r_rd = 8'($urandom);
                  check("rand_pending_cmd", cmd_q.size() > 0, 1);
                  r_c = (cmd_q.size() > 0) ? cmd_q.pop_front() : 16'h0;
                  check("rand_drv", {drv_rw, drv_addr, drv_wdata}, r_c);
                  r_err = r_d0 >= TO || r_d1 >= TO;
                  rsp_q.push_back({r_err, (!r_err && r_c[15]) ? r_rd : 8'h00});
                  drive_busy(r_d0, r_d1, r_rd);
               end
            end
         end
         begin
            while (got < NR && c_cyc < 6000) begin
               @(posedge clk); #1;
               rsp_ready = ($urandom_range(0, 3) != 0);
               @(negedge clk);
               c_cyc++;
               if (hold) check("rand_hold", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, held});
               if (rsp_valid && rsp_ready) begin
                  check("rand_pending_rsp", rsp_q.size() > 0, 1);
                  e = (rsp_q.size() > 0) ? rsp_q.pop_front() : 9'h0;
                  check("rand_rsp", {rsp_err, rsp_rdata}, e);
                  got++;
               end
               hold = rsp_valid && !rsp_ready;
               held = {rsp_err, rsp_rdata};
            end
            check("rand_all", got, NR);
            done = 1'b1;
         end
      join
      check("rand_drained", cmd_q.size() + rsp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
